// File: rtl/midi_pkg.sv
// midi_pkg: constants and types shared by the MIDI input path.
//   MIDI_BAUD        nominal MIDI line rate
//   MIDI_RT_MIN      first System Real-Time status byte
//   NOTE_OFF/NOTE_ON/CTRL_CHANGE  status nibbles used by the decoder
//   uart_rx_state_t  receiver FSM states
package midi_pkg;

  localparam int         MIDI_BAUD   = 31_250;
  localparam logic [7:0] MIDI_RT_MIN = 8'hF8;

  localparam logic [3:0] NOTE_OFF    = 4'h8;
  localparam logic [3:0] NOTE_ON     = 4'h9;
  localparam logic [3:0] CTRL_CHANGE = 4'hB;

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  // System Real-Time bytes (clock, start, stop, active sensing, ...)
  function automatic logic is_realtime(input logic [7:0] b);
    return b >= MIDI_RT_MIN;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous input.
//   clk     system clock
//   reset   synchronous, active-high; both flops load RESET_VAL
//   line    asynchronous input
//   synced  input re-timed to clk, two cycles late
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic synced
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= line;
      sync_reg <= meta_reg;
    end
  end

  assign synced = sync_reg;

endmodule

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: 8N1 receiver for the MIDI input line.
//   clk            system clock
//   reset          synchronous, active-high
//   midi_rx        asynchronous serial line, idle high
//   MIDIbyte       last accepted byte, held until the next one
//   ready          one-cycle pulse: MIDIbyte newly valid
//   framing_error  one-cycle pulse: stop bit sampled low
//   busy           FSM is anywhere but IDLE
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = 50_000_000,
  parameter int BAUD_RATE       = MIDI_BAUD,
  parameter bit FILTER_REALTIME = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       midi_rx,
  output logic [7:0] MIDIbyte,
  output logic       ready,
  output logic       framing_error,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_rate_check
      $error("midi_uart_rx: CLKS_PER_BIT must be at least 4");
    end
  endgenerate

  logic rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .line   (midi_rx),
    .synced (rx_s)
  );

  uart_rx_state_t   state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next;
  logic [7:0]       sh_reg, sh_next;
  logic [7:0]       byte_reg, byte_next;
  logic             ready_reg, ready_next;
  logic             fe_reg, fe_next;
  // The synchroniser leaves reset holding 1 for two cycles regardless of
  // the real line level, so WAIT_HIGH ignores rx_s until it has flushed.
  // Otherwise a line held low through reset would look like a fresh start.
  logic [1:0]       settle_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= WAIT_HIGH;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      sh_reg     <= '0;
      byte_reg   <= '0;
      ready_reg  <= 1'b0;
      fe_reg     <= 1'b0;
      settle_reg <= 2'd2;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      sh_reg    <= sh_next;
      byte_reg  <= byte_next;
      ready_reg <= ready_next;
      fe_reg    <= fe_next;
      if (settle_reg != 2'd0) settle_reg <= settle_reg - 2'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    sh_next    = sh_reg;
    byte_next  = byte_reg;
    ready_next = 1'b0;
    fe_next    = 1'b0;

    case (state_reg)
      WAIT_HIGH: begin
        if (settle_reg == 2'd0 && rx_s) state_next = IDLE;
      end

      IDLE: begin
        if (!rx_s) begin
          cnt_next   = HALF_LOAD;
          state_next = START;
        end
      end

      // Half a bit later the line must still be low, else it was a glitch.
      START: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else if (!rx_s) begin
          cnt_next   = FULL_LOAD;
          idx_next   = 3'd0;
          state_next = DATA;
        end else begin
          state_next = IDLE;
        end
      end

      DATA: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          sh_next  = {rx_s, sh_reg[7:1]};
          cnt_next = FULL_LOAD;
          if (idx_reg == 3'd7) state_next = STOP;
          else                 idx_next   = idx_reg + 3'd1;
        end
      end

      // Returning to IDLE at the stop mid-sample leaves half a bit of
      // margin before a back-to-back start edge can arrive.
      STOP: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else if (rx_s) begin
          if (!(FILTER_REALTIME && is_realtime(sh_reg))) begin
            byte_next  = sh_reg;
            ready_next = 1'b1;
          end
          state_next = IDLE;
        end else begin
          fe_next    = 1'b1;
          state_next = WAIT_HIGH;
        end
      end

      default: state_next = WAIT_HIGH;
    endcase
  end

  assign MIDIbyte      = byte_reg;
  assign ready         = ready_reg;
  assign framing_error = fe_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_midi_uart_rx.sv
module tb_midi_uart_rx;

  // Scaled clock so a bit is 16 cycles; timing rules are the same.
  localparam int CLK_HZ = 500_000;
  localparam int BAUD   = 31_250;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int LAT    = 2 + CPB / 2 + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       midi_rx = 1'b1;
  logic [7:0] byte_f, byte_n;
  logic       ready_f, ready_n, fe_f, fe_n, busy_f, busy_n;

  midi_uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .FILTER_REALTIME(1'b1)) dut (
    .clk(clk), .reset(reset), .midi_rx(midi_rx),
    .MIDIbyte(byte_f), .ready(ready_f), .framing_error(fe_f), .busy(busy_f));

  midi_uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .FILTER_REALTIME(1'b0)) dut_nf (
    .clk(clk), .reset(reset), .midi_rx(midi_rx),
    .MIDIbyte(byte_n), .ready(ready_n), .framing_error(fe_n), .busy(busy_n));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int   rdy_f_cnt = 0, rdy_n_cnt = 0, fe_f_cnt = 0, fe_n_cnt = 0;
  int   last_rdy_cyc = 0, bad_pulse_cnt = 0;
  logic p_rf = 0, p_rn = 0, p_ef = 0, p_en = 0;

  always @(negedge clk) begin
    if (reset) begin
      p_rf = 0; p_rn = 0; p_ef = 0; p_en = 0;
    end else begin
      if (ready_f) begin rdy_f_cnt++; last_rdy_cyc = cyc; end
      if (ready_n) rdy_n_cnt++;
      if (fe_f) fe_f_cnt++;
      if (fe_n) fe_n_cnt++;
      if ((ready_f && fe_f) || (ready_n && fe_n) || (ready_f && p_rf) ||
          (ready_n && p_rn) || (fe_f && p_ef) || (fe_n && p_en))
        bad_pulse_cnt++;
      p_rf = ready_f; p_rn = ready_n; p_ef = fe_f; p_en = fe_n;
    end
  end

  int passed = 0, total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Reference model: outcome of one frame from the protocol rules alone.
  function automatic void model(input logic [7:0] d, input logic stop,
                                output bit rf, output bit rn, output bit fe);
    fe = !stop;
    rn = stop;
    rf = stop && (d < 8'hF8);
  endfunction

  logic [7:0] exp_f = 8'h00, exp_n = 8'h00;
  bit         b2b_pending = 0;
  int         b2b_cyc = 0;

  task automatic run_frame(input logic [7:0] d, input logic stop, input int idle,
                           input bit rf, input bit rn, input bit fe, input string tag);
    int r0 = rdy_f_cnt;
    int n0 = rdy_n_cnt;
    int e0 = fe_f_cnt;
    int en0 = fe_n_cnt;
    int fall;
    midi_rx = 1'b0;
    fall = cyc;
    tick(CPB);
    for (int b = 0; b < 8; b++) begin
      midi_rx = d[b];
      tick(CPB);
    end
    midi_rx = stop;
    tick(CPB);
    if (!stop) begin
      tick(5 * CPB);
      midi_rx = 1'b1;
      tick(CPB);
    end
    midi_rx = 1'b1;
    tick(idle * CPB);
    $display("frame %s data=%02h stop=%0b idle=%0d ready_f=%0d ready_n=%0d fe=%0d byte_f=%02h byte_n=%02h",
             tag, d, stop, idle, rdy_f_cnt - r0, rdy_n_cnt - n0, fe_f_cnt - e0, byte_f, byte_n);
    chk({tag, ".ready_f"}, rdy_f_cnt - r0, rf);
    chk({tag, ".ready_n"}, rdy_n_cnt - n0, rn);
    chk({tag, ".fe_f"}, fe_f_cnt - e0, fe);
    chk({tag, ".fe_n"}, fe_n_cnt - en0, fe);
    if (rf) exp_f = d;
    if (rn) exp_n = d;
    chk({tag, ".byte_f"}, byte_f, exp_f);
    chk({tag, ".byte_n"}, byte_n, exp_n);
    chk({tag, ".busy"}, {busy_f, busy_n}, 2'b00);
    if (rf) begin
      chk({tag, ".latency"}, last_rdy_cyc - fall, LAT);
      if (b2b_pending) chk({tag, ".spacing"}, last_rdy_cyc - b2b_cyc, 10 * CPB);
    end
    b2b_pending = rf && (idle == 0);
    b2b_cyc = last_rdy_cyc;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         idle;
    bit         rf;
    bit         rn;
    bit         fe;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int r0, e0;
    tbl[0]  = '{8'h90, 1'b1, 2, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{8'hB0, 1'b1, 0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{8'h15, 1'b1, 0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{8'h65, 1'b1, 2, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{8'h45, 1'b0, 2, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{8'h40, 1'b1, 2, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{8'hF8, 1'b1, 2, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{8'h90, 1'b1, 2, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{8'hF7, 1'b1, 2, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{8'hFF, 1'b1, 0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{8'h00, 1'b1, 2, 1'b1, 1'b1, 1'b0};

    // Reset state.
    tick(3);
    chk("rst.byte", {byte_f, byte_n}, 16'h0000);
    chk("rst.ready", {ready_f, ready_n}, 2'b00);
    chk("rst.fe", {fe_f, fe_n}, 2'b00);
    chk("rst.busy", {busy_f, busy_n}, 2'b11);
    reset = 1'b0;
    tick(5 * CPB);
    chk("idle.busy", {busy_f, busy_n}, 2'b00);

    for (int i = 0; i < 11; i++)
      run_frame(tbl[i].data, tbl[i].stop, tbl[i].idle, tbl[i].rf, tbl[i].rn, tbl[i].fe,
                $sformatf("v%0d", i));

    // Short low glitch: shorter than half a bit, must be rejected.
    r0 = rdy_n_cnt; e0 = fe_n_cnt;
    midi_rx = 1'b0;
    tick(CPB / 2 - 3);
    midi_rx = 1'b1;
    tick(2 * CPB);
    $display("glitch low=%0d cycles ready=%0d fe=%0d busy=%0b", CPB / 2 - 3,
             rdy_n_cnt - r0, fe_n_cnt - e0, busy_f);
    chk("glitch.ready", rdy_n_cnt - r0, 0);
    chk("glitch.fe", fe_n_cnt - e0, 0);
    chk("glitch.busy", {busy_f, busy_n}, 2'b00);
    run_frame(8'h80, 1'b1, 2, 1'b1, 1'b1, 1'b0, "after_glitch");

    // Reset during bit 4 of 0x7F, line held low across release.
    r0 = rdy_n_cnt; e0 = fe_n_cnt;
    midi_rx = 1'b0;
    tick(CPB);
    for (int b = 0; b < 4; b++) begin
      midi_rx = 1'b1;
      tick(CPB);
    end
    tick(CPB / 2);
    midi_rx = 1'b0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    exp_f = 8'h00; exp_n = 8'h00;
    b2b_pending = 0;
    tick(3 * CPB);
    $display("midreset low ready=%0d fe=%0d busy=%0b byte=%02h",
             rdy_n_cnt - r0, fe_n_cnt - e0, busy_f, byte_f);
    chk("midreset.ready", rdy_n_cnt - r0, 0);
    chk("midreset.fe", fe_n_cnt - e0, 0);
    chk("midreset.wait_busy", {busy_f, busy_n}, 2'b11);
    midi_rx = 1'b1;
    tick(2 * CPB);
    chk("midreset.idle_busy", {busy_f, busy_n}, 2'b00);
    chk("midreset.byte", {byte_f, byte_n}, 16'h0000);
    run_frame(8'h05, 1'b1, 2, 1'b1, 1'b1, 1'b0, "after_reset");

    // Randomised frames against the reference model.
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      logic stop;
      bit rf, rn, fe;
      d = 8'($urandom_range(0, 255));
      if (i % 4 == 0) d = 8'hF8 | 8'($urandom_range(0, 7));
      stop = ($urandom_range(0, 5) != 0);
      model(d, stop, rf, rn, fe);
      run_frame(d, stop, $urandom_range(0, 2), rf, rn, fe, $sformatf("r%0d", i));
    end

    chk("pulse_shape", bad_pulse_cnt, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
